// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the FP unit: rounding modes, flag layout,
// constants, divider FSM states and small unpack / lzc / rounding helpers.
package fp16_pkg;

    localparam int QBITS = 14;

    localparam logic [7:0]  BIAS   = 8'd15;
    localparam logic [15:0] QNAN   = 16'h7E00;
    localparam logic [15:0] POSINF = 16'h7C00;
    localparam logic [15:0] MAXFIN = 16'h7BFF;

    // Bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } roundmode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_ROUND,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
        logic       is_sub;   // exponent field zero (subnormal or zero)
        logic       is_zero;
        logic       is_inf;
        logic       is_nan;
        logic       is_snan;
    } fp16_unp_t;

    // Split a binary16 word into fields plus classification bits.
    function automatic fp16_unp_t unpack(input logic [15:0] v);
        fp16_unp_t u;
        u.sign    = v[15];
        u.exp     = v[14:10];
        u.frac    = v[9:0];
        u.is_sub  = (v[14:10] == 5'd0);
        u.is_zero = (v[14:10] == 5'd0) && (v[9:0] == 10'd0);
        u.is_inf  = (v[14:10] == 5'h1F) && (v[9:0] == 10'd0);
        u.is_nan  = (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
        u.is_snan = (v[14:10] == 5'h1F) && (v[9:0] != 10'd0) && !v[9];
        return u;
    endfunction

    // Leading-zero count of an 11-bit significand; 11 for an all-zero input.
    function automatic logic [3:0] lzc11(input logic [10:0] v);
        logic [3:0] n;
        n = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (v[i]) n = 4'(10 - i);
        end
        return n;
    endfunction

    // Whether to add one ulp, given the kept lsb, the first dropped bit and
    // the OR of everything below it.
    function automatic logic round_inc(input roundmode_e rm, input logic sign,
                                       input logic lsb, input logic g,
                                       input logic rest);
        logic inc;
        case (rm)
            RM_RZ:   inc = 1'b0;
            RM_RNE:  inc = g & (rest | lsb);
            RM_RDN:  inc = sign & (g | rest);
            RM_RUP:  inc = !sign & (g | rest);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fdiv16_if.sv
// Operand/result handshake bundle between the FP issue logic and fdiv16.
interface fdiv16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  roundmode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    modport master (
        output in_valid, x, y, roundmode, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, x, y, roundmode, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp16_round.sv
// Final rounding and packing for binary16. Takes a normalized significand
// {1.f[9:0], G, R, S} with a biased, possibly non-positive exponent,
// denormalizes when needed, rounds, and flags overflow/underflow/inexact.
// Tininess is judged after rounding with an unbounded exponent.
module fp16_round
    import fp16_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [7:0] exp_i,
    input  logic [13:0]       sig_i,
    input  roundmode_e        rm_i,
    output logic [15:0]       result_o,
    output logic              of_o,
    output logic              uf_o,
    output logic              nx_o
);

    logic        inc_unb;
    logic        carry_unb;
    logic        tiny;
    logic [3:0]  sh;
    logic [25:0] wide;
    logic [10:0] sig11;
    logic        g;
    logic        r;
    logic        s;
    logic        inexact;
    logic        inc;
    logic [11:0] sum;
    logic [7:0]  base;
    logic [17:0] field;
    logic        keep_max;

    // Denormalize, round, pack and derive the exception flags.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every
        // path (defaults first where branches differ) so no latch is inferred.
        result_o = 16'h0000;
        uf_o     = 1'b0;
        nx_o     = 1'b0;

        // Rounding as if the exponent range were unbounded: only a carry out
        // of an all-ones significand at exponent 0 lifts the value to normal.
        inc_unb   = round_inc(rm_i, sign_i, sig_i[3], sig_i[2], |sig_i[1:0]);
        carry_unb = (&sig_i[13:3]) & inc_unb;
        tiny      = (exp_i < 8'sd0) || ((exp_i == 8'sd0) && !carry_unb);

        // Right-shift by (1 - exp) for subnormal results, capped at 13.
        if (exp_i > 8'sd0)
            sh = 4'd0;
        else if (exp_i < -8'sd12)
            sh = 4'd13;
        else
            sh = 4'd1 - exp_i[3:0];

        wide    = {sig_i[13:1], 13'b0} >> sh;
        sig11   = wide[25:15];
        g       = wide[14];
        r       = wide[13];
        s       = sig_i[0] | (|wide[12:0]);
        inexact = g | r | s;

        inc = round_inc(rm_i, sign_i, sig11[0], g, r | s);
        sum = {1'b0, sig11} + {11'b0, inc};

        // Adding the significand (hidden bit included) onto (exp-1)<<10 lets a
        // rounding carry ripple straight into the exponent field.
        base  = (exp_i > 8'sd0) ? 8'(exp_i - 8'sd1) : 8'd0;
        field = {base, 10'b0} + {6'b0, sum};
        of_o  = (field[17:10] >= 8'd31);

        keep_max = (rm_i == RM_RZ)
                || ((rm_i == RM_RDN) && !sign_i)
                || ((rm_i == RM_RUP) && sign_i);

        if (of_o) begin
            result_o = (keep_max ? MAXFIN : POSINF) | {sign_i, 15'b0};
            nx_o     = 1'b1;
        end else begin
            result_o = {sign_i, field[14:0]};
            nx_o     = inexact;
            uf_o     = tiny & inexact;
        end
    end

endmodule

// File: rtl/fdiv16.sv
// Iterative binary16 divider (x / y), radix-2 restoring, one quotient bit per
// clock. IDLE -> PREP -> ITER -> ROUND -> DONE. Special operands skip ITER;
// ROUND then just forwards the result prepared in PREP.
module fdiv16
    import fp16_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    fdiv16_if.slave bus
);

    state_e            state_q,     state_d;
    logic [15:0]       x_q,         x_d;
    logic [15:0]       y_q,         y_d;
    roundmode_e        rm_q,        rm_d;
    logic              qs_q,        qs_d;
    logic signed [7:0] qe_q,        qe_d;
    logic [11:0]       rem_q,       rem_d;
    logic [10:0]       div_q,       div_d;
    logic [QBITS-1:0]  quo_q,       quo_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              special_q,   special_d;
    logic [15:0]       result_q,    result_d;
    logic [4:0]        flags_q,     flags_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;

    // PREP datapath
    fp16_unp_t         ux;
    fp16_unp_t         uy;
    logic [3:0]        lzx;
    logic [3:0]        lzy;
    logic [10:0]       mx;
    logic [10:0]       my;
    logic signed [7:0] qe_prep;
    logic              qs_prep;
    logic              is_special;
    logic [15:0]       spec_result;
    logic [4:0]        spec_flags;

    // ITER / ROUND datapath
    logic              rem_ge;
    logic [11:0]       rem_sub;
    logic [QBITS-1:0]  quo_n;
    logic signed [7:0] qe_n;
    logic [13:0]       rnd_sig;
    logic [15:0]       rnd_result;
    logic              rnd_of;
    logic              rnd_uf;
    logic              rnd_nx;

    // Unpack latched operands, normalize subnormals, form Qe and resolve specials.
    always_comb begin
        ux  = unpack(x_q);
        uy  = unpack(y_q);
        lzx = lzc11({!ux.is_sub, ux.frac});
        lzy = lzc11({!uy.is_sub, uy.frac});
        mx  = {!ux.is_sub, ux.frac} << lzx;
        my  = {!uy.is_sub, uy.frac} << lzy;

        qe_prep = {3'b0, (ux.is_sub ? 5'd1 : ux.exp)} - {4'b0, lzx}
                - {3'b0, (uy.is_sub ? 5'd1 : uy.exp)} + {4'b0, lzy} + BIAS;
        qs_prep = ux.sign ^ uy.sign;

        is_special  = ux.is_nan | uy.is_nan | ux.is_inf | uy.is_inf
                    | ux.is_zero | uy.is_zero;
        spec_result = 16'h0000;
        spec_flags  = 5'b0;
        if (ux.is_nan || uy.is_nan) begin
            spec_result         = QNAN;
            spec_flags[FLAG_NV] = ux.is_snan | uy.is_snan;
        end else if ((ux.is_zero && uy.is_zero) || (ux.is_inf && uy.is_inf)) begin
            spec_result         = QNAN;
            spec_flags[FLAG_NV] = 1'b1;
        end else if (uy.is_zero && !ux.is_inf) begin
            spec_result         = POSINF | {qs_prep, 15'b0};
            spec_flags[FLAG_DZ] = 1'b1;
        end else if (ux.is_inf) begin
            spec_result = POSINF | {qs_prep, 15'b0};
        end else begin
            spec_result = {qs_prep, 15'b0};
        end
    end

    // One restoring step plus post-loop normalization feeding the rounder.
    always_comb begin
        rem_ge  = (rem_q >= {1'b0, div_q});
        rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

        if (quo_q[QBITS-1]) begin
            quo_n = quo_q;
            qe_n  = qe_q;
        end else begin
            quo_n = quo_q << 1;
            qe_n  = qe_q - 8'sd1;
        end
        // The slack bit below round joins the sticky so nothing is dropped.
        rnd_sig = {quo_n[QBITS-1:1], quo_n[0] | (|rem_q)};
    end

    fp16_round u_round (
        .sign_i   (qs_q),
        .exp_i    (qe_n),
        .sig_i    (rnd_sig),
        .rm_i     (rm_q),
        .result_o (rnd_result),
        .of_o     (rnd_of),
        .uf_o     (rnd_uf),
        .nx_o     (rnd_nx)
    );

    // Next-state and next-datapath selection for the divider FSM.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        rm_d      = rm_q;
        qs_d      = qs_q;
        qe_d      = qe_q;
        rem_d     = rem_q;
        div_d     = div_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        special_d = special_q;
        result_d  = result_q;
        flags_d   = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.x;
                    y_d     = bus.y;
                    rm_d    = roundmode_e'(bus.roundmode);
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                qs_d = qs_prep;
                if (is_special) begin
                    special_d = 1'b1;
                    result_d  = spec_result;
                    flags_d   = spec_flags;
                    state_d   = ST_ROUND;
                end else begin
                    special_d = 1'b0;
                    qe_d      = qe_prep;
                    rem_d     = {1'b0, mx};
                    div_d     = my;
                    quo_d     = '0;
                    cnt_d     = 4'(QBITS - 1);
                    state_d   = ST_ITER;
                end
            end
            ST_ITER: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[QBITS-2:0], rem_ge};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (!special_q) begin
                    result_d          = rnd_result;
                    flags_d           = 5'b0;
                    flags_d[FLAG_OF]  = rnd_of;
                    flags_d[FLAG_UF]  = rnd_uf;
                    flags_d[FLAG_NX]  = rnd_nx;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // All state and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            rm_q        <= RM_RZ;
            qs_q        <= 1'b0;
            qe_q        <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            special_q   <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rm_q        <= rm_d;
            qs_q        <= qs_d;
            qe_q        <= qe_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            special_q   <= special_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fdiv16.sv
// Self-checking bench for fdiv16: expected results are queued when an
// operation is issued and popped when the divider presents its output.
module tb_fdiv16;
    import fp16_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    fdiv16_if bus ();

    fdiv16 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_res_q[$];
    logic [4:0]  exp_flg_q[$];
    int          exp_lat_q[$];
    string       exp_tag_q[$];

    localparam logic [4:0] F_NONE  = 5'b00000;
    localparam logic [4:0] F_NV    = 5'b10000;
    localparam logic [4:0] F_DZ    = 5'b01000;
    localparam logic [4:0] F_OFNX  = 5'b00101;
    localparam logic [4:0] F_UFNX  = 5'b00011;
    localparam logic [4:0] F_NX    = 5'b00001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Issue one operation, wait for its result, compare against the scoreboard.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] rm, input logic [15:0] er, input logic [4:0] ef,
                          input int elat, input int hold);
        int          waited;
        int          lat;
        logic        stable;
        logic [15:0] r0;
        logic [4:0]  f0;
        string       t;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);

        bus.x         = a;
        bus.y         = b;
        bus.roundmode = rm;
        bus.in_valid  = 1'b1;
        exp_res_q.push_back(er);
        exp_flg_q.push_back(ef);
        exp_lat_q.push_back(elat);
        exp_tag_q.push_back(tag);

        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end

        t = exp_tag_q.pop_front();
        check({t, "_lat"}, 32'(lat), 32'(exp_lat_q.pop_front()));

        if (hold > 0) begin
            stable = 1'b1;
            r0 = bus.result;
            f0 = bus.flags;
            repeat (hold) begin
                @(posedge clk); #1;
                if (bus.result !== r0 || bus.flags !== f0 ||
                    bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                    stable = 1'b0;
            end
            check({t, "_hold"}, 32'(stable), 32'd1);
        end

        check({t, "_res"}, 32'(bus.result), 32'(exp_res_q.pop_front()));
        check({t, "_flg"}, 32'(bus.flags),  32'(exp_flg_q.pop_front()));

        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = 16'h0000;
        bus.y         = 16'h0000;
        bus.roundmode = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'h0000);
        check("rst_flags",     32'(bus.flags),     32'h00);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Normal quotients
        run_op("one_half",   16'h3C00, 16'h4000, RM_RNE, 16'h3800, F_NONE, 16, 0);
        run_op("third_rne",  16'h3C00, 16'h4200, RM_RNE, 16'h3555, F_NX,   16, 0);
        run_op("third_rz",   16'h3C00, 16'h4200, RM_RZ,  16'h3555, F_NX,   16, 0);
        run_op("third_rup",  16'h3C00, 16'h4200, RM_RUP, 16'h3556, F_NX,   16, 0);
        run_op("nthird_rdn", 16'h3C00, 16'hC200, RM_RDN, 16'hB556, F_NX,   16, 0);
        run_op("neg_two",    16'h4400, 16'hC000, RM_RNE, 16'hC000, F_NONE, 16, 0);

        // Specials
        run_op("div_zero",   16'h3C00, 16'h0000, RM_RNE, 16'h7C00, F_DZ,   2, 0);
        run_op("zero_zero",  16'h0000, 16'h0000, RM_RNE, 16'h7E00, F_NV,   2, 0);
        run_op("snan",       16'h7D00, 16'h3C00, RM_RNE, 16'h7E00, F_NV,   2, 0);
        run_op("qnan",       16'h7E00, 16'h3C00, RM_RNE, 16'h7E00, F_NONE, 2, 0);
        run_op("inf_inf",    16'h7C00, 16'hFC00, RM_RNE, 16'h7E00, F_NV,   2, 0);
        run_op("ninf_fin",   16'hFC00, 16'h4000, RM_RNE, 16'hFC00, F_NONE, 2, 0);
        run_op("fin_inf",    16'h3C00, 16'h7C00, RM_RNE, 16'h0000, F_NONE, 2, 0);
        run_op("nzero_fin",  16'h8000, 16'h4000, RM_RNE, 16'h8000, F_NONE, 2, 0);

        // Overflow
        run_op("ovf_rne",    16'h7BFF, 16'h1400, RM_RNE, 16'h7C00, F_OFNX, 16, 0);
        run_op("ovf_rz",     16'h7BFF, 16'h1400, RM_RZ,  16'h7BFF, F_OFNX, 16, 0);
        run_op("novf_rup",   16'hFBFF, 16'h1400, RM_RUP, 16'hFBFF, F_OFNX, 16, 0);
        run_op("ovf_subdiv", 16'h3C00, 16'h0001, RM_RNE, 16'h7C00, F_OFNX, 16, 0);

        // Subnormal inputs and results
        run_op("sub_exact",  16'h0400, 16'h4400, RM_RNE, 16'h0100, F_NONE, 16, 0);
        run_op("unf_rne",    16'h0001, 16'h4000, RM_RNE, 16'h0000, F_UFNX, 16, 0);
        run_op("unf_rup",    16'h0001, 16'h4000, RM_RUP, 16'h0001, F_UFNX, 16, 0);
        run_op("sub_to_min", 16'h0200, 16'h3800, RM_RNE, 16'h0400, F_NONE, 16, 0);

        // Result held while the consumer stalls
        run_op("hold",       16'h3C00, 16'h4200, RM_RNE, 16'h3555, F_NX,   16, 10);

        // Reset in the middle of ITER abandons the operation
        bus.x         = 16'h3C00;
        bus.y         = 16'h4200;
        bus.roundmode = RM_RNE;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        seen_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("post_rst_no_output", 32'(seen_valid), 32'd0);

        run_op("after_rst",  16'h4400, 16'hC000, RM_RNE, 16'hC000, F_NONE, 16, 0);
        run_op("after_rst2", 16'h3C00, 16'h4200, RM_RUP, 16'h3556, F_NX,   16, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
